// File: rtl/move_gen_pkg.sv
// Shared types and constants for the move-generation sequencer.
package move_gen_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SCAN = 3'd1,
        REQ  = 3'd2,
        EMIT = 3'd3,
        DONE = 3'd4
    } seqState_t;

    localparam int PIECE_CNT = 16;

    localparam logic [3:0] P1 = 4'd15;
    localparam logic [3:0] P2 = 4'd14;
    localparam logic [3:0] P3 = 4'd13;
    localparam logic [3:0] P4 = 4'd12;
    localparam logic [3:0] P5 = 4'd11;
    localparam logic [3:0] P6 = 4'd10;
    localparam logic [3:0] P7 = 4'd9;
    localparam logic [3:0] P8 = 4'd8;
    localparam logic [3:0] R1 = 4'd7;
    localparam logic [3:0] R2 = 4'd6;
    localparam logic [3:0] N1 = 4'd5;
    localparam logic [3:0] N2 = 4'd4;
    localparam logic [3:0] B1 = 4'd3;
    localparam logic [3:0] B2 = 4'd2;
    localparam logic [3:0] Q1 = 4'd1;
    localparam logic [3:0] K1 = 4'd0;

    localparam logic WHITE = 1'b1;
    localparam logic BLACK = 1'b0;

    // 6-bit location field of piece idx: [2:0] = row, [5:3] = col.
    function automatic logic [5:0] pieceField(input logic [95:0] vec, input logic [3:0] idx);
        return vec[int'(idx) * 6 +: 6];
    endfunction

endpackage

// File: rtl/piece_prio_enc.sv
// Highest-set-bit encoder over the 16-entry pending piece mask.
module piece_prio_enc (
    input  logic [15:0] mask,
    output logic        found,
    output logic [3:0]  index
);

    always_comb begin
        found = 1'b0;
        index = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (mask[i]) begin
                found = 1'b1;
                index = 4'(i);
            end
        end
    end

endmodule

// File: rtl/move_gen_sequencer.sv
// Walks the alive pieces of the side to move (15 down to 0), requests move generation per piece
// and streams per-piece counts plus a saturating total. Optional feature: MOVE_SEQ_TIMEOUT_EN.
module move_gen_sequencer
    import move_gen_pkg::*;
#(
    parameter int CNT_W = 5,
    parameter int TOT_W = 8
`ifdef MOVE_SEQ_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 64
`endif
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             player,
    input  logic [95:0]      locationVectorWhite,
    input  logic [95:0]      locationVectorBlack,
    input  logic [15:0]      aliveVectorWhite,
    input  logic [15:0]      aliveVectorBlack,
    output logic             gen_req,
    output logic [3:0]       gen_piece,
    output logic [2:0]       gen_row,
    output logic [2:0]       gen_col,
    output logic             gen_player,
    input  logic             gen_ack,
    input  logic [CNT_W-1:0] gen_count,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_piece,
    output logic [CNT_W-1:0] out_count,
    output logic             busy,
    output logic             done,
    output logic [TOT_W-1:0] total_moves
`ifdef MOVE_SEQ_TIMEOUT_EN
    ,
    output logic             timeout_err
`endif
);

    localparam int SUM_W = TOT_W + 1;

    seqState_t     state;
    seqState_t     nextState;
    logic [95:0]   snapLoc;
    logic [15:0]   pendMask;
    logic          encFound;
    logic [3:0]    encIdx;
    logic [5:0]    encField;
    logic          tmoExpired;

    function automatic logic [TOT_W-1:0] satAdd(input logic [TOT_W-1:0] acc,
                                                input logic [CNT_W-1:0] inc);
        logic [SUM_W-1:0] sum;
        sum = {1'b0, acc} + SUM_W'(inc);
        return sum[TOT_W] ? {TOT_W{1'b1}} : sum[TOT_W-1:0];
    endfunction

    piece_prio_enc prioEnc (
        .mask  (pendMask),
        .found (encFound),
        .index (encIdx)
    );

    assign encField = pieceField(snapLoc, encIdx);

`ifdef MOVE_SEQ_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT) + 1;
    logic [TMO_W-1:0] tmoCnt;

    assign tmoExpired = (tmoCnt == TMO_W'(TIMEOUT - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tmoCnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                timeout_err <= 1'b0;
            end
            if (state == SCAN) begin
                tmoCnt <= '0;
            end else if (state == REQ && !gen_ack) begin
                tmoCnt <= tmoCnt + 1'b1;
                if (tmoExpired) begin
                    timeout_err <= 1'b1;
                end
            end
        end
    end
`else
    assign tmoExpired = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (start) nextState = SCAN;
            SCAN:    nextState = encFound ? REQ : DONE;
            REQ:     if (gen_ack || tmoExpired) nextState = EMIT;
            EMIT:    if (out_ready) nextState = SCAN;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    assign gen_req   = (state == REQ);
    assign out_valid = (state == EMIT);
    assign busy      = (state == SCAN) || (state == REQ) || (state == EMIT);
    assign done      = (state == DONE);

    // Snapshot, per-piece request fields and result capture
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            snapLoc     <= '0;
            pendMask    <= '0;
            gen_player  <= 1'b0;
            gen_piece   <= '0;
            gen_row     <= '0;
            gen_col     <= '0;
            out_piece   <= '0;
            out_count   <= '0;
            total_moves <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        gen_player  <= player;
                        snapLoc     <= (player == WHITE) ? locationVectorWhite : locationVectorBlack;
                        pendMask    <= (player == WHITE) ? aliveVectorWhite : aliveVectorBlack;
                        total_moves <= '0;
                    end
                end
                SCAN: begin
                    if (encFound) begin
                        pendMask[encIdx] <= 1'b0;
                        gen_piece        <= encIdx;
                        gen_row          <= encField[2:0];
                        gen_col          <= encField[5:3];
                    end
                end
                REQ: begin
                    if (gen_ack) begin
                        out_piece   <= gen_piece;
                        out_count   <= gen_count;
                        total_moves <= satAdd(total_moves, gen_count);
                    end else if (tmoExpired) begin
                        out_piece <= gen_piece;
                        out_count <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_move_gen_sequencer.sv
// Directed, table-driven bench for move_gen_sequencer plus hand sequences for reset and timeout.
module tb_move_gen_sequencer;
    import move_gen_pkg::*;

    localparam int CNT_W = 5;
    localparam int TOT_W = 8;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic             player = 1'b0;
    logic [95:0]      locationVectorWhite = '0;
    logic [95:0]      locationVectorBlack = '0;
    logic [15:0]      aliveVectorWhite = '0;
    logic [15:0]      aliveVectorBlack = '0;
    logic             gen_req;
    logic [3:0]       gen_piece;
    logic [2:0]       gen_row;
    logic [2:0]       gen_col;
    logic             gen_player;
    logic             gen_ack = 1'b0;
    logic [CNT_W-1:0] gen_count = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [3:0]       out_piece;
    logic [CNT_W-1:0] out_count;
    logic             busy;
    logic             done;
    logic [TOT_W-1:0] total_moves;
`ifdef MOVE_SEQ_TIMEOUT_EN
    logic             timeout_err;
`endif

    int nChecks = 0;
    int nFail   = 0;

    logic [95:0] locW0;
    logic [95:0] locB0;

    move_gen_sequencer #(.CNT_W(CNT_W), .TOT_W(TOT_W)) dut (
        .clock               (clock),
        .reset               (reset),
        .start               (start),
        .player              (player),
        .locationVectorWhite (locationVectorWhite),
        .locationVectorBlack (locationVectorBlack),
        .aliveVectorWhite    (aliveVectorWhite),
        .aliveVectorBlack    (aliveVectorBlack),
        .gen_req             (gen_req),
        .gen_piece           (gen_piece),
        .gen_row             (gen_row),
        .gen_col             (gen_col),
        .gen_player          (gen_player),
        .gen_ack             (gen_ack),
        .gen_count           (gen_count),
        .out_valid           (out_valid),
        .out_ready           (out_ready),
        .out_piece           (out_piece),
        .out_count           (out_count),
        .busy                (busy),
        .done                (done),
        .total_moves         (total_moves)
`ifdef MOVE_SEQ_TIMEOUT_EN
        ,
        .timeout_err         (timeout_err)
`endif
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required end of test");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        player;
        logic [15:0] aliveW;
        logic [15:0] aliveB;
        logic [79:0] counts;
        int          ackDelay;
        int          readyDelay;
        int          expTotal;
        int          expRecs;
        int          expDone;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        nChecks++;
        if (act != exp) begin
            nFail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [95:0] makeLoc(input int seed);
        logic [95:0] v;
        v = '0;
        for (int i = 0; i < 16; i++) begin
            v[6*i +: 3]   = 3'((i + seed) % 8);
            v[6*i+3 +: 3] = 3'((i * 3 + seed) % 8);
        end
        return v;
    endfunction

    function automatic int highest(input logic [15:0] m);
        for (int i = 15; i >= 0; i--) begin
            if (m[i]) return i;
        end
        return -1;
    endfunction

    function automatic int cntOf(input logic [79:0] c, input int p);
        if (p < 0) return 0;
        return int'(c[5*p +: 5]);
    endfunction

    task automatic pulseStart(input logic pl, input logic [15:0] aw, input logic [15:0] ab);
        @(negedge clock);
        player = pl;
        locationVectorWhite = locW0;
        locationVectorBlack = locB0;
        aliveVectorWhite = aw;
        aliveVectorBlack = ab;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic runSweep(input vec_t v);
        int cyc, nRec, reqAge, vAge, ackCyc, doneCyc, doneCnt, firstReq, expP;
        logic [15:0] rem;
        logic [95:0] loc;
        loc = v.player ? locW0 : locB0;
        rem = v.player ? v.aliveW : v.aliveB;
        pulseStart(v.player, v.aliveW, v.aliveB);
        // Scramble every input vector; the sweep must run from its snapshot.
        player = ~v.player;
        locationVectorWhite = ~locW0;
        locationVectorBlack = ~locB0;
        aliveVectorWhite = ~v.aliveW;
        aliveVectorBlack = ~v.aliveB;
        cyc = 1; nRec = 0; reqAge = 0; vAge = 0; ackCyc = -100;
        doneCyc = -1; doneCnt = 0; firstReq = -1;
        while (doneCyc < 0 && cyc < 2000) begin
            gen_ack = 1'b0; gen_count = '0; out_ready = 1'b0; start = 1'b0;
            expP = highest(rem);
            if (cyc == 3) start = 1'b1;
            if (gen_req) begin
                if (firstReq < 0) firstReq = cyc;
                check("gen_piece", int'(gen_piece), expP);
                check("gen_row", int'(gen_row), int'(loc[6*(expP & 15) +: 3]));
                check("gen_col", int'(gen_col), int'(loc[6*(expP & 15)+3 +: 3]));
                check("gen_player", int'(gen_player), int'(v.player));
                if (reqAge == v.ackDelay) begin
                    gen_ack = 1'b1;
                    gen_count = 5'(cntOf(v.counts, expP));
                    ackCyc = cyc;
                    reqAge = 0;
                end else begin
                    reqAge++;
                end
            end
            if (out_valid) begin
                check("out_piece", int'(out_piece), expP);
                check("out_count", int'(out_count), cntOf(v.counts, expP));
                check("gen_req_during_emit", int'(gen_req), 0);
                if (vAge >= v.readyDelay) begin
                    out_ready = 1'b1;
                    if (expP >= 0) rem[expP] = 1'b0;
                    nRec++;
                    vAge = 0;
                end else begin
                    vAge++;
                    gen_ack = 1'b1;
                    gen_count = '1;
                end
            end
            if (v.readyDelay == 0 && ackCyc >= 0) begin
                if (cyc == ackCyc + 1) check("out_valid_after_ack", int'(out_valid), 1);
                if (cyc == ackCyc + 3 && rem != 16'h0) check("next_req_t3", int'(gen_req), 1);
            end
            if (done) begin
                doneCyc = cyc;
                doneCnt++;
                check("busy_in_done", int'(busy), 0);
                check("total_at_done", int'(total_moves), v.expTotal);
                start = 1'b1;
            end
            @(negedge clock);
            cyc++;
        end
        start = 1'b0;
        if (doneCyc < 0) check("sweep_cycle_budget", 0, 1);
        check("done_cycle", doneCyc, v.expDone);
        check("done_pulses", doneCnt, 1);
        check("records", nRec, v.expRecs);
        check("first_req_cycle", firstReq, (v.expRecs > 0) ? 2 : -1);
        check("done_one_cycle", int'(done), 0);
        check("idle_after_done", int'(busy), 0);
        check("total_held", int'(total_moves), v.expTotal);
        @(negedge clock);
        check("start_in_done_ignored", int'(busy), 0);
        check("no_req_idle", int'(gen_req), 0);
    endtask

    vec_t vecs [5];
    logic [79:0] cTmp;

    initial begin
        locW0 = makeLoc(1);
        locB0 = makeLoc(4);

        vecs[0] = '{player: WHITE, aliveW: 16'hFFFF, aliveB: 16'h0000, counts: {16{5'd2}},
                    ackDelay: 3, readyDelay: 0, expTotal: 32, expRecs: 16, expDone: 98};
        cTmp = '0;
        cTmp[5*15 +: 5] = 5'd4;
        cTmp[0 +: 5]    = 5'd7;
        vecs[1] = '{player: BLACK, aliveW: 16'hFFFF, aliveB: 16'h8001, counts: cTmp,
                    ackDelay: 1, readyDelay: 0, expTotal: 11, expRecs: 2, expDone: 10};
        vecs[2] = '{player: WHITE, aliveW: 16'h0000, aliveB: 16'hFFFF, counts: {16{5'd3}},
                    ackDelay: 0, readyDelay: 0, expTotal: 0, expRecs: 0, expDone: 2};
        cTmp = '0;
        cTmp[5*14 +: 5] = 5'd5;
        cTmp[5*3 +: 5]  = 5'd6;
        vecs[3] = '{player: WHITE, aliveW: 16'h4008, aliveB: 16'h0000, counts: cTmp,
                    ackDelay: 0, readyDelay: 10, expTotal: 11, expRecs: 2, expDone: 28};
        vecs[4] = '{player: WHITE, aliveW: 16'hFFFF, aliveB: 16'hFFFF, counts: {16{5'd27}},
                    ackDelay: 0, readyDelay: 0, expTotal: 255, expRecs: 16, expDone: 50};

        // Reset state
        repeat (2) @(negedge clock);
        check("rst_gen_req", int'(gen_req), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_total", int'(total_moves), 0);
        check("rst_gen_piece", int'(gen_piece), 0);
        check("rst_out_count", int'(out_count), 0);
        reset = 1'b1;

        // Stray ack while idle must not disturb anything
        @(negedge clock);
        gen_ack = 1'b1; gen_count = 5'd9;
        @(negedge clock);
        gen_ack = 1'b0; gen_count = '0;
        check("idle_ack_ignored", int'(total_moves), 0);

        // Reset asserted in the middle of a request
        pulseStart(WHITE, 16'hFFFF, 16'h0000);
        @(negedge clock);
        check("seq_req_c2", int'(gen_req), 1);
        check("seq_piece_c2", int'(gen_piece), int'(P1));
        gen_ack = 1'b1; gen_count = 5'd9;
        @(negedge clock);
        gen_ack = 1'b0; gen_count = '0;
        check("seq_valid_c3", int'(out_valid), 1);
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        check("seq_total_9", int'(total_moves), 9);
        @(negedge clock);
        check("seq_req_c5", int'(gen_req), 1);
        #2 reset = 1'b0;
        #1;
        check("async_rst_gen_req", int'(gen_req), 0);
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_total", int'(total_moves), 0);
        check("async_rst_out_valid", int'(out_valid), 0);
        @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < 5; i++) begin
            runSweep(vecs[i]);
        end

`ifdef MOVE_SEQ_TIMEOUT_EN
        pulseStart(WHITE, 16'h0020, 16'h0000);
        repeat (64) @(negedge clock);
        check("tmo_req_c65", int'(gen_req), 1);
        check("tmo_err_before", int'(timeout_err), 0);
        @(negedge clock);
        check("tmo_valid_c66", int'(out_valid), 1);
        check("tmo_req_dropped", int'(gen_req), 0);
        check("tmo_piece", int'(out_piece), 5);
        check("tmo_count", int'(out_count), 0);
        check("tmo_err_set", int'(timeout_err), 1);
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        @(negedge clock);
        check("tmo_done", int'(done), 1);
        pulseStart(WHITE, 16'h0000, 16'h0000);
        check("tmo_err_cleared", int'(timeout_err), 0);
        repeat (3) @(negedge clock);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/move_gen_sequencer.md
Name: move_gen_sequencer

Overview:
- Sequences per-piece move generation for the side to move.
- On start, snapshots the board vectors and walks the alive pieces from index 15 (P1) down to 0 (K1).
- For each alive piece it issues one request to the piece move-generator datapath and waits for its acknowledge. It then streams a per-piece result record to the search logic and keeps a running move total.

Parameters:
- CNT_W, 5, width of the per-piece move count returned by the generator (max 27 moves/piece).
- TOT_W, 8, width of the total move counter; saturates at 2^TOT_W-1.
- TIMEOUT, 64, cycles to wait for gen_ack before abandoning a piece (used only with the optional feature).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a sweep when idle, ignored when busy.
- player  in  1  side to move: 1 = white, 0 = black.
- locationVectorWhite  in  96  piece i at [6i+:6]: row [6i+:3], col [6i+3+:3].
- locationVectorBlack  in  96  same layout as white.
- aliveVectorWhite  in  16  bit i = piece i alive.
- aliveVectorBlack  in  16  bit i = piece i alive.
- gen_req  out  1  request to generator; held until gen_ack.
- gen_piece  out  4  piece ID (P1=15 … K1=0).
- gen_row  out  3  row of the requested piece.
- gen_col  out  3  column of the requested piece.
- gen_player  out  1  latched player.
- gen_ack  in  1  generator done; gen_count valid in the same cycle.
- gen_count  in  CNT_W  number of moves found for the piece.
- out_valid  out  1  per-piece result valid.
- out_ready  in  1  consumer accepts the result.
- out_piece  out  4  piece ID of the result.
- out_count  out  CNT_W  move count of the result.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse at end of sweep.
- total_moves  out  TOT_W  sum of counts for the sweep; held until the next start.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE. All outputs 0, including gen_req, out_valid, busy, done and total_moves. Internal mask and snapshot registers are cleared.
- States: IDLE, SCAN, REQ, EMIT, DONE.
- IDLE: when start=1, latch player, the own-side location vector and the own-side alive vector as the pending mask. Clear total_moves, set busy=1 and go to SCAN.
- SCAN: takes 1 cycle.
  - Pick the highest set bit of the pending mask and clear that bit.
  - Load gen_piece/gen_row/gen_col from the snapshot, then go to REQ.
  - If the mask is empty, go to DONE.
- REQ: gen_req=1 with stable fields until gen_ack=1.
  - On the ack cycle, capture gen_count into out_count and out_piece.
  - Add gen_count to total_moves, saturating at 2^TOT_W-1.
  - Drop gen_req the next cycle and go to EMIT.
  - gen_ack while not in REQ is ignored.
- EMIT: out_valid=1 with stable data until out_ready=1; then go to SCAN. Backpressure stalls the sweep indefinitely.
- DONE: done=1 for exactly one cycle and busy=0, then go to IDLE. total_moves holds its value.
- Latency:
  - start in cycle 0 gives gen_req in cycle 2.
  - gen_ack with immediate ready gives out_valid in cycle t+1.
  - The next gen_req is in cycle t+3, where t is the ack cycle.
- Boundaries:
  - All-dead side: start leads to SCAN, then DONE; the done pulse comes at cycle 2 and total_moves=0.
  - Input vectors changing mid-sweep have no effect, because they are snapshotted.
  - start during busy is ignored, including in the DONE cycle.
  - reset mid-operation aborts immediately: gen_req and out_valid drop asynchronously.

Optional Feature:
- Macro: MOVE_SEQ_TIMEOUT_EN.
- Defined:
  - A counter runs while in REQ.
  - If TIMEOUT cycles elapse without gen_ack: drop gen_req, emit the record with out_count=0, and set sticky output timeout_err (1 bit, cleared by start or reset).
  - After the EMIT handshake the sweep continues with the next piece.
- Undefined: no counter and no timeout_err port; REQ waits forever.

Decomposition:
- Package move_gen_pkg:
  - State enum.
  - Piece ID constants P1..P8, R1, R2, N1, N2, B1, B2, Q1, K1.
  - Colour constants WHITE=1 and BLACK=0.
  - A 6-bit field helper for row/col extraction.
- Sub-module piece_prio_enc: 16-bit mask → {found, 4-bit index of highest set bit}. It is purely combinational and is used by SCAN.

Test Plan:
- White, all 16 alive, gen_ack 3 cycles after each req with gen_count=2, out_ready=1 → 16 records in order 15..0, total_moves=32, done pulsed once, gen_req first at cycle 2.
- Black, only bits {15,0} alive, counts 4 and 7 → records (15,4) then (0,7), total_moves=11, white vectors ignored.
- Alive vector all 0, start → done at cycle 2, no gen_req, total_moves=0.
- out_ready held low for 10 cycles on the first record → out_valid and fields stable; no second gen_req until accepted.
- Assert reset while in REQ → gen_req=0, busy=0, total_moves=0 immediately; a new start then sweeps correctly. With MOVE_SEQ_TIMEOUT_EN and no gen_ack → record count 0 after 64 cycles and timeout_err=1.
